// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg
// Shared definitions for the data_mem_resp memory responder slice.
// Contents:
//   WORD_W, BE_W : data word width and byte-enable width
//   CNT_W        : width of the grant-delay and response-latency counters
//   state_t      : responder FSM state encoding (idle, waiting for grant, responding)
//   idxWidth()   : number of word-index bits needed for a given RAM depth
// Optional feature macro used by the files that import this package: MEM_RESP_BE_EN

package mem_resp_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // A depth of one still needs a one-bit index so that the port slices stay legal.
  function automatic int idxWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// data_mem_resp_if
// Bundle for the req/gnt/r_valid memory protocol between an initiator and
// the data_mem_resp responder.
// Parameter: ADDR_W - byte address width.
// Signals:
//   req     initiator -> responder  request, fields held stable until gnt
//   addr    initiator -> responder  byte address (low two bits ignored)
//   we      initiator -> responder  0 = read, 1 = write
//   wdata   initiator -> responder  write data
//   be      initiator -> responder  byte enables (only with MEM_RESP_BE_EN)
//   gnt     responder -> initiator  request accepted this cycle
//   r_valid responder -> initiator  one-cycle response strobe
//   rdata   responder -> initiator  read data, valid with r_valid
// Modports: master (initiator side), slave (responder side).
// Macro: MEM_RESP_BE_EN adds the be signal.

interface data_mem_resp_if #(
  parameter int ADDR_W = 32
);
  import mem_resp_pkg::*;

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [WORD_W-1:0] wdata;
`ifdef MEM_RESP_BE_EN
  logic [BE_W-1:0]   be;
`endif
  logic              gnt;
  logic              r_valid;
  logic [WORD_W-1:0] rdata;

  modport master (
`ifdef MEM_RESP_BE_EN
    output be,
`endif
    output req, addr, we, wdata,
    input  gnt, r_valid, rdata
  );

  modport slave (
`ifdef MEM_RESP_BE_EN
    input  be,
`endif
    input  req, addr, we, wdata,
    output gnt, r_valid, rdata
  );

endinterface

// File: rtl/mem_resp_ram.sv
// mem_resp_ram
// Synchronous single-port word RAM with a registered read port and per-byte
// write lanes. The read register only loads on a read access, so it keeps the
// last read word across writes and idle cycles.
// Parameters: DEPTH (words), IDX_W (word-index width, derived from DEPTH).
// Ports:
//   clk      in   clock
//   i_en     in   access strobe for this cycle
//   i_we     in   1 = write, 0 = read
//   i_idx    in   word index
//   i_wdata  in   write data
//   i_be     in   byte-lane write enables
//   o_rdata  out  registered read data
// The RAM has no reset: contents survive a responder reset.

module mem_resp_ram
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = idxWidth(DEPTH)
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [BE_W-1:0]   i_be,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  // One access per enabled cycle: writes update only the enabled byte lanes,
  // reads load the output register with the addressed word as it was before
  // this edge.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (i_be[b]) begin
            r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[i_idx];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp
// Responder end of the req/gnt/r_valid memory protocol. Grants a request
// after GNT_DELAY cycles of req, commits writes and samples reads at the
// grant edge, and returns one r_valid pulse RVALID_LAT cycles after the grant.
// Parameters:
//   ADDR_W     byte address width
//   DEPTH      RAM depth in 32-bit words (power of two); addresses wrap
//   GNT_DELAY  cycles req must be held before gnt (0 = same cycle)
//   RVALID_LAT cycles from gnt to r_valid (at least 1)
// Ports:
//   clk  in  clock, all state changes on the rising edge
//   rst  in  synchronous active-high reset (RAM contents are kept)
//   bus  data_mem_resp_if.slave: req/addr/we/wdata/[be] in, gnt/r_valid/rdata out
// Macro: MEM_RESP_BE_EN enables byte-lane writes through bus.be; without it
// every write updates the full word.

module data_mem_resp
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DEPTH      = 1024,
  parameter int GNT_DELAY  = 0,
  parameter int RVALID_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_resp_if.slave bus
);

  localparam int IDX_W = idxWidth(DEPTH);
  localparam logic [CNT_W-1:0] GD_C  = CNT_W'(GNT_DELAY);
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(RVALID_LAT);

  state_t            r_state;
  state_t            w_stateNext;
  logic [CNT_W-1:0]  r_waitCnt;
  logic [CNT_W-1:0]  w_waitNext;
  logic [CNT_W-1:0]  r_respCnt;
  logic [CNT_W-1:0]  w_respNext;
  logic              r_pendRead;
  logic [WORD_W-1:0] r_rdata;
  logic              w_accept;
  logic              w_gntRaw;
  logic              w_rvalidRaw;
  logic              w_gnt;
  logic              w_rvalid;
  logic [WORD_W-1:0] w_ramRdata;
  logic [BE_W-1:0]   w_be;
  logic              w_unusedAddr;

  // Next-state logic. w_accept marks the cycles in which a new request may be
  // taken: plain idle, and the r_valid cycle of the previous transaction, which
  // is what allows one transaction per cycle with zero grant delay.
  always_comb begin
    w_stateNext = r_state;
    w_waitNext  = r_waitCnt;
    w_respNext  = r_respCnt;
    w_accept    = 1'b0;
    w_gntRaw    = 1'b0;
    w_rvalidRaw = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_accept = 1'b1;
      end
      ST_WAIT: begin
        if (!bus.req) begin
          w_stateNext = ST_IDLE;
          w_waitNext  = '0;
        end else if (r_waitCnt == GD_C) begin
          w_gntRaw    = 1'b1;
          w_stateNext = ST_RESP;
          w_waitNext  = '0;
          w_respNext  = CNT_W'(1);
        end else begin
          w_waitNext = r_waitCnt + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (r_respCnt == LAT_C) begin
          w_rvalidRaw = 1'b1;
          w_stateNext = ST_IDLE;
          w_respNext  = '0;
          w_accept    = 1'b1;
        end else begin
          w_respNext = r_respCnt + CNT_W'(1);
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
        w_waitNext  = '0;
        w_respNext  = '0;
      end
    endcase

    if (w_accept && bus.req) begin
      if (GNT_DELAY == 0) begin
        w_gntRaw    = 1'b1;
        w_stateNext = ST_RESP;
        w_respNext  = CNT_W'(1);
      end else begin
        w_stateNext = ST_WAIT;
        w_waitNext  = CNT_W'(1);
      end
    end
  end

  // Reset masks the strobes so that a write presented in the reset cycle is
  // never committed and a pending response never surfaces.
  assign w_gnt    = w_gntRaw & ~rst;
  assign w_rvalid = w_rvalidRaw & ~rst;

  // State, counters and the read-result register. r_pendRead remembers whether
  // the outstanding transaction is a read, so write responses leave rdata alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_waitCnt  <= '0;
      r_respCnt  <= '0;
      r_pendRead <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_waitCnt <= w_waitNext;
      r_respCnt <= w_respNext;
      if (w_gnt) begin
        r_pendRead <= ~bus.we;
      end
      if (w_rvalid && r_pendRead) begin
        r_rdata <= w_ramRdata;
      end
    end
  end

`ifdef MEM_RESP_BE_EN
  assign w_be = bus.be;
`else
  assign w_be = '1;
`endif

  // Only the word-index bits reach the RAM; the rest of the address is ignored.
  assign w_unusedAddr = ^bus.addr[ADDR_W-1:0];

  mem_resp_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_gnt),
    .i_we    (bus.we),
    .i_idx   (bus.addr[IDX_W+1:2]),
    .i_wdata (bus.wdata),
    .i_be    (w_be),
    .o_rdata (w_ramRdata)
  );

  // In a read's r_valid cycle the RAM register already holds the answer, so it
  // is forwarded directly; otherwise the last read result is held.
  assign bus.gnt     = w_gnt;
  assign bus.r_valid = w_rvalid;
  assign bus.rdata   = (w_rvalid && r_pendRead) ? w_ramRdata : r_rdata;

endmodule
